// File: rtl/codec_cfg_seq.sv
// codec_cfg_seq: I2C master that writes a fixed 7-entry register table to the CODEC after a start pulse.
// Define CODEC_CFG_RETRY_EN to retry a NACKed entry up to 3 times before flagging an error.
module codec_cfg_seq #(
    parameter int         CLK_DIV  = 46,
    parameter logic [6:0] DEV_ADDR = 7'h1A
) (
    input  logic       bclk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       sda_in,
    output logic       scl_oe,
    output logic       sda_oe,
    output logic       busy,
    output logic       cfg_done,
    output logic       cfg_err,
    output logic [2:0] err_idx
);
    localparam int PW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [PW-1:0] PH_LAST = PW'(CLK_DIV - 1);
    // {reg[6:0], data[8:0]}; R7 = master mode, left-justified, 16-bit
    localparam logic [15:0] TBL [8] = '{
        {7'd15, 9'h000}, {7'd4, 9'h014}, {7'd5, 9'h000}, {7'd6, 9'h000},
        {7'd7, 9'h041}, {7'd8, 9'h000}, {7'd9, 9'h001}, 16'h0000
    };

    typedef enum logic [2:0] {IDLE, START, BIT, ACK, STOP, GAP, DONE, ERR} state_t;

    state_t          st_q, st_d;
    logic [PW-1:0]   ph_q, ph_d;
    logic [1:0]      pi_q, pi_d;
    logic [2:0]      bit_q, bit_d;
    logic [1:0]      byte_q, byte_d;
    logic [2:0]      idx_q, idx_d;
    logic [2:0]      err_q, err_d;
    logic            nack_q, nack_d;
`ifdef CODEC_CFG_RETRY_EN
    logic [1:0]      try_q, try_d;
`endif
    logic [15:0]     ent;
    logic [7:0]      byte_v;
    logic            bit_v, ph_end, st_end;

    assign busy     = st_q != IDLE && st_q != DONE && st_q != ERR;
    assign scl_oe   = (st_q == BIT || st_q == ACK) && (pi_q == 2'd0 || pi_q == 2'd3);
    assign sda_oe   = st_q == START || (st_q == BIT && !bit_v) || (st_q == STOP && pi_q == 2'd0);
    assign cfg_done = st_q == DONE;
    assign cfg_err  = st_q == ERR;
    assign err_idx  = err_q;

    always_ff @(posedge bclk) begin
        if (!rst_n) begin
            st_q   <= IDLE;
            ph_q   <= '0;
            pi_q   <= '0;
            bit_q  <= '0;
            byte_q <= '0;
            idx_q  <= '0;
            err_q  <= '0;
            nack_q <= 1'b0;
`ifdef CODEC_CFG_RETRY_EN
            try_q  <= '0;
`endif
        end else begin
            st_q   <= st_d;
            ph_q   <= ph_d;
            pi_q   <= pi_d;
            bit_q  <= bit_d;
            byte_q <= byte_d;
            idx_q  <= idx_d;
            err_q  <= err_d;
            nack_q <= nack_d;
`ifdef CODEC_CFG_RETRY_EN
            try_q  <= try_d;
`endif
        end
    end

    always_comb begin
        ent    = TBL[idx_q];
        byte_v = byte_q == 2'd0 ? {DEV_ADDR, 1'b0} : byte_q == 2'd1 ? ent[15:8] : ent[7:0];
        bit_v  = byte_v[3'd7 - bit_q];
        ph_end = ph_q == PH_LAST;
        // START and STOP are two phases long, the other active states four
        st_end = ph_end && pi_q == ((st_q == START || st_q == STOP) ? 2'd1 : 2'd3);
        st_d   = st_q;
        ph_d   = (!busy || ph_end) ? '0 : ph_q + PW'(1);
        pi_d   = (!busy || st_end) ? 2'd0 : ph_end ? pi_q + 2'd1 : pi_q;
        bit_d  = bit_q;
        byte_d = byte_q;
        idx_d  = idx_q;
        err_d  = err_q;
        nack_d = (st_q == ACK && ph_end && pi_q == 2'd2) ? sda_in : nack_q;
`ifdef CODEC_CFG_RETRY_EN
        try_d  = try_q;
`endif
        case (st_q)
            IDLE: if (start) st_d = START;
            START: if (st_end) begin
                st_d   = BIT;
                bit_d  = '0;
                byte_d = '0;
                nack_d = 1'b0;
            end
            BIT: if (st_end) begin
                st_d  = bit_q == 3'd7 ? ACK : BIT;
                bit_d = bit_q == 3'd7 ? bit_q : bit_q + 3'd1;
            end
            ACK: if (st_end) begin
                st_d   = (byte_q == 2'd2 || nack_q) ? STOP : BIT;
                byte_d = (byte_q == 2'd2 || nack_q) ? byte_q : byte_q + 2'd1;
                bit_d  = '0;
            end
            STOP: if (st_end) st_d = GAP;
            GAP: if (st_end) begin
                st_d  = nack_q ? ERR : idx_q == 3'd6 ? DONE : START;
                idx_d = (nack_q || idx_q == 3'd6) ? idx_q : idx_q + 3'd1;
`ifdef CODEC_CFG_RETRY_EN
                st_d  = (nack_q && try_q != 2'd3) ? START : st_d;
                try_d = (nack_q && try_q != 2'd3) ? try_q + 2'd1 : 2'd0;
`endif
                err_d = st_d == ERR ? idx_q : err_q;
            end
            default: st_d = st_q;
        endcase
    end
endmodule

// File: tb/tb_codec_cfg_seq.sv
// tb_codec_cfg_seq: directed bench for codec_cfg_seq with a bus-level I2C slave that decodes bytes and ACKs/NACKs on demand.
module tb_codec_cfg_seq;
    logic       bclk = 1'b0, rst_n = 1'b0, start = 1'b0;
    logic       scl_oe, sda_oe, busy, cfg_done, cfg_err;
    logic [2:0] err_idx;
    logic       scl, sda, slv_pull = 1'b0;

    int total = 0, bad = 0;

    logic       p_scl = 1'b1, p_sda = 1'b1;
    logic [3:0] nbit = '0;
    logic [1:0] nbyte = '0;
    logic [7:0] sh = '0, cur_reg = '0;
    int         cyc = 0, n_start = 0, n_r5 = 0, n_r6 = 0, once_hits = 0;
    logic [7:0] got[$];
    int         st_t[$];

    logic       perm_en = 1'b0;
    logic [7:0] perm_reg = '0;
    int         once_limit = 0;

    logic [7:0] EXP [21] = '{8'h34, 8'h1E, 8'h00, 8'h34, 8'h08, 8'h14, 8'h34, 8'h0A, 8'h00,
                             8'h34, 8'h0C, 8'h00, 8'h34, 8'h0E, 8'h41, 8'h34, 8'h10, 8'h00,
                             8'h34, 8'h12, 8'h01};

    assign scl = ~scl_oe;
    assign sda = ~(sda_oe | slv_pull);

    always #5 bclk = ~bclk;

    codec_cfg_seq #(.CLK_DIV(4), .DEV_ADDR(7'h1A)) dut (
        .bclk(bclk), .rst_n(rst_n), .start(start), .sda_in(sda),
        .scl_oe(scl_oe), .sda_oe(sda_oe), .busy(busy),
        .cfg_done(cfg_done), .cfg_err(cfg_err), .err_idx(err_idx)
    );

    // slave: decode START/STOP and bytes, ACK unless a NACK is requested
    always @(posedge bclk) begin
        cyc   <= cyc + 1;
        p_scl <= scl;
        p_sda <= sda;
        if (!rst_n) begin
            nbit     <= '0;
            slv_pull <= 1'b0;
        end else if (p_scl && scl && p_sda && !sda) begin
            nbit     <= '0;
            nbyte    <= '0;
            slv_pull <= 1'b0;
            n_start  <= n_start + 1;
            st_t.push_back(cyc);
        end else if (p_scl && scl && !p_sda && sda) begin
            nbit     <= '0;
            slv_pull <= 1'b0;
        end else if (!p_scl && scl) begin
            if (nbit < 4'd8) begin
                sh   <= {sh[6:0], sda};
                nbit <= nbit + 4'd1;
            end else nbit <= 4'd9;
        end else if (p_scl && !scl) begin
            if (nbit == 4'd8) begin
                got.push_back(sh);
                if (nbyte == 2'd1) cur_reg <= sh;
                if (nbyte == 2'd1 && sh == 8'h0A) n_r5 <= n_r5 + 1;
                if (nbyte == 2'd1 && sh == 8'h0C) n_r6 <= n_r6 + 1;
                if (nbyte == 2'd1 && perm_en && sh == perm_reg) slv_pull <= 1'b0;
                else if (nbyte == 2'd2 && cur_reg == 8'h0E && once_hits < once_limit) begin
                    slv_pull  <= 1'b0;
                    once_hits <= once_hits + 1;
                end else slv_pull <= 1'b1;
            end else if (nbit == 4'd9) begin
                slv_pull <= 1'b0;
                nbit     <= '0;
                nbyte    <= nbyte + 2'd1;
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", tag, act, exp);
        end
    endtask

    function automatic logic [31:0] gb(input int i);
        return (i < got.size()) ? {24'h0, got[i]} : 32'hDEAD;
    endfunction

    function automatic int tdiff(input int i);
        return (i + 1 < st_t.size()) ? st_t[i+1] - st_t[i] : -1;
    endfunction

    task automatic chk_entry(input int pos, input int e);
        for (int j = 0; j < 3; j++) chk($sformatf("e%0d_b%0d", e, j), gb(pos + j), {24'h0, EXP[3*e+j]});
    endtask

    task automatic go();
        chk("busy_pre", busy, 0);
        start = 1'b1;
        @(negedge bclk);
        start = 1'b0;
        chk("busy_rise", busy, 1);
    endtask

    task automatic wait_idle(input int poke, output int n);
        n = 0;
        while (busy && n < 20000) begin
            start = (n == poke);
            n++;
            @(negedge bclk);
        end
        start = 1'b0;
        chk("idle_timeout", busy, 0);
    endtask

    task automatic rst();
        rst_n = 1'b0;
        @(negedge bclk);
        rst_n = 1'b1;
    endtask

    initial begin
        int n, b, s0, t0, r5, r6;
        repeat (3) @(negedge bclk);
        chk("rst_scl", scl_oe, 0);
        chk("rst_sda", sda_oe, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", cfg_done, 0);
        chk("rst_err", cfg_err, 0);
        chk("rst_idx", err_idx, 0);
        rst_n = 1'b1;
        @(negedge bclk);
        // full sequence, extra start pulse while busy
        b = got.size(); s0 = n_start; t0 = st_t.size();
        chk("pre_sda", sda_oe, 0);
        go();
        chk("first_sda", sda_oe, 1);
        chk("first_scl", scl_oe, 0);
        wait_idle(1000, n);
        chk("busy_len", n, 3248);
        chk("done", cfg_done, 1);
        chk("done_err", cfg_err, 0);
        chk("done_lines", {scl_oe, sda_oe}, 0);
        chk("nbytes", got.size() - b, 21);
        for (int e = 0; e < 7; e++) chk_entry(b + 3 * e, e);
        chk("ntrans", n_start - s0, 7);
        for (int i = 0; i < 6; i++) chk($sformatf("txn_len%0d", i), tdiff(t0 + i), 464);
        // start after done is ignored
        s0 = n_start;
        start = 1'b1;
        @(negedge bclk);
        start = 1'b0;
        repeat (600) @(negedge bclk);
        chk("post_ntrans", n_start - s0, 0);
        chk("post_busy", busy, 0);
        chk("post_done", cfg_done, 1);
        chk("post_err", cfg_err, 0);
        // single NACK on entry 4 data byte
        rst();
        once_limit = once_hits + 1;
        b = got.size(); s0 = n_start;
        go();
        wait_idle(-1, n);
        chk("nack1_hit", once_hits, once_limit);
`ifdef CODEC_CFG_RETRY_EN
        chk("nack1_done", cfg_done, 1);
        chk("nack1_err", cfg_err, 0);
        chk("nack1_nbytes", got.size() - b, 24);
        chk("nack1_ntrans", n_start - s0, 8);
        for (int e = 0; e < 5; e++) chk_entry(b + 3 * e, e);
        chk_entry(b + 15, 4);
        chk_entry(b + 18, 5);
        chk_entry(b + 21, 6);
`else
        chk("nack1_done", cfg_done, 0);
        chk("nack1_err", cfg_err, 1);
        chk("nack1_idx", err_idx, 4);
        chk("nack1_nbytes", got.size() - b, 15);
        chk("nack1_ntrans", n_start - s0, 5);
`endif
        // permanent NACK on entry 2 register byte
        rst();
        perm_reg = 8'h0A;
        perm_en = 1'b1;
        r5 = n_r5; r6 = n_r6;
        go();
        wait_idle(-1, n);
        perm_en = 1'b0;
`ifdef CODEC_CFG_RETRY_EN
        chk("perm_attempts", n_r5 - r5, 4);
`else
        chk("perm_attempts", n_r5 - r5, 1);
`endif
        chk("perm_no_e3", n_r6 - r6, 0);
        chk("perm_err", cfg_err, 1);
        chk("perm_done", cfg_done, 0);
        chk("perm_idx", err_idx, 2);
        chk("perm_lines", {scl_oe, sda_oe}, 0);
        // reset in the middle of entry 3 data byte
        rst();
        r6 = n_r6;
        go();
        n = 0;
        while (n_r6 == r6 && n < 5000) begin
            n++;
            @(negedge bclk);
        end
        chk("reach_e3", n_r6 - r6, 1);
        repeat (50) @(negedge bclk);
        chk("mid_busy", busy, 1);
        rst_n = 1'b0;
        @(negedge bclk);
        rst_n = 1'b1;
        chk("mrst_scl", scl_oe, 0);
        chk("mrst_sda", sda_oe, 0);
        chk("mrst_busy", busy, 0);
        chk("mrst_done", cfg_done, 0);
        @(negedge bclk);
        b = got.size();
        go();
        wait_idle(-1, n);
        chk_entry(b, 0);
        chk("restart_nbytes", got.size() - b, 21);
        chk("restart_done", cfg_done, 1);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/codec_cfg_seq.md
CODEC_CFG_SEQ -- requirements
Module: codec_cfg_seq

Interface
REQ-001 The block SHALL have parameter: CLK_DIV, 46, bclk cycles per I2C quarter-bit phase (about 100 kHz SCL at 18.432 MHz).
REQ-002 The block SHALL have parameter: DEV_ADDR, 7'h1A, 7-bit CODEC I2C address.
REQ-003 The block SHALL have port: bclk  input  1  sole clock; every flop rises on bclk.
REQ-004 The block SHALL have port: rst_n  input  1  synchronous, active-low reset.
REQ-005 The block SHALL have port: start  input  1  one-cycle pulse that begins the configuration sequence.
REQ-006 The block SHALL have port: sda_in  input  1  sampled SDA line level.
REQ-007 The block SHALL have port: scl_oe  output  1  1 pulls SCL low; 0 releases SCL.
REQ-008 The block SHALL have port: sda_oe  output  1  1 pulls SDA low; 0 releases SDA.
REQ-009 The block SHALL have port: busy  output  1  high while the sequence runs.
REQ-010 The block SHALL have port: cfg_done  output  1  sticky high after all table writes are ACKed; gates the mic sample path.
REQ-011 The block SHALL have port: cfg_err  output  1  sticky high after an unrecovered NACK.
REQ-012 The block SHALL have port: err_idx  output  3  table index of the failing write.

Function
REQ-013 The block SHALL hold a fixed 7-entry table of {reg[6:0], data[8:0]} writes, issued in this order: (R15,0x000), (R4,0x014), (R5,0x000), (R6,0x000), (R7,0x041: master mode, left-justified, 16-bit), (R8,0x000), (R9,0x001).
REQ-014 Each write SHALL be one I2C transaction: START, byte {DEV_ADDR,0}, byte {reg,data[8]}, byte data[7:0], STOP; bytes are MSB-first, each followed by an ACK slot.
REQ-015 The FSM SHALL have the states IDLE, START, BIT, ACK, STOP, GAP, DONE and ERR.
REQ-016 The FSM transitions SHALL be:
- IDLE->START on start;
- START->BIT;
- BIT->ACK after 8 bits;
- ACK->BIT for the next byte, or ACK->STOP after byte 3 or on NACK;
- STOP->GAP;
- GAP->START for the next entry, or GAP->DONE or ERR.
REQ-017 Each phase SHALL last exactly CLK_DIV cycles, counted by a phase counter.
REQ-018 A bit SHALL be 4 phases: SCL low with SDA set up; SCL high; SCL high; SCL low.
REQ-019 START SHALL drive SDA low while SCL is released, for 2 phases, then pull SCL low.
REQ-020 STOP SHALL hold SDA low with SCL released for 1 phase, then release SDA for 1 phase.
REQ-021 During the ACK slot, SDA SHALL be released, and sda_in SHALL be sampled on the last cycle of phase 2; 0 = ACK, 1 = NACK.
REQ-022 GAP SHALL hold both lines released for 4 phases.
REQ-023 scl_oe and sda_oe SHALL change first on the cycle after start is sampled.
REQ-024 busy SHALL be high from that cycle until the cycle DONE or ERR is entered.
REQ-025 The start pulse SHALL be ignored while busy is high or in DONE/ERR; only reset re-arms the block.
REQ-026 In DONE, cfg_done SHALL be 1 with both lines released; in ERR, cfg_err SHALL be 1, err_idx SHALL hold the failing index, and both lines SHALL be released.
REQ-027 cfg_done and cfg_err SHALL never both be 1.
REQ-028 The phase counter SHALL be wide enough for CLK_DIV-1, the bit counter SHALL be 3 bits, the byte counter 2 bits and the table index 3 bits; none wraps within one sequence.

Reset
REQ-029 While rst_n=0 at a bclk edge, the block SHALL set state=IDLE, scl_oe=0, sda_oe=0, busy=0, cfg_done=0, cfg_err=0, err_idx=0 and clear all counters.
REQ-030 A reset mid-transaction SHALL release both lines on the next cycle, abandon the sequence and issue no STOP.
REQ-031 The first start after release of rst_n SHALL restart the sequence at entry 0.

Configuration
REQ-032 With CODEC_CFG_RETRY_EN defined, a NACK SHALL complete STOP and GAP, then retry the same entry, up to 3 retries; the 4th consecutive NACK on that entry SHALL go to ERR.
REQ-033 The retry counter SHALL clear on each successful entry.
REQ-034 Without CODEC_CFG_RETRY_EN, the first NACK SHALL go to ERR after STOP.

Verification
REQ-035 The bench SHALL run with CLK_DIV=4 and an I2C slave model that always ACKs; after start, the decoded bytes SHALL be exactly 34 1E 00 / 34 08 14 / 34 0A 00 / 34 0C 00 / 34 0E 41 / 34 10 00 / 34 12 01, ending with cfg_done=1, busy=0 and cfg_err=0.
REQ-036 The bench SHALL check, with CLK_DIV=4, that each transaction lasts 2+27*4+2+4 phases = 116 phases = 464 cycles, and that busy rises 1 cycle after start.
REQ-037 The bench SHALL NACK the data byte of entry 4 once: with CODEC_CFG_RETRY_EN, entry 4 SHALL be resent and cfg_done=1; without it, cfg_err=1 and err_idx=4.
REQ-038 The bench SHALL NACK entry 2 permanently with CODEC_CFG_RETRY_EN: exactly 4 attempts SHALL occur, then cfg_err=1, err_idx=2, and no entry-3 traffic.
REQ-039 The bench SHALL assert rst_n=0 for 1 cycle during a byte of entry 3: scl_oe=sda_oe=busy=0 on the next cycle; a new start SHALL restart from entry 0 (first bytes 34 1E 00).
REQ-040 The bench SHALL pulse start while busy and again after cfg_done: no extra transactions and no state disturbance SHALL result.
